lane_packer: RTL and testbench

- Upstream stage of the per-lane add/subtract array.
- Accepts one lane at a time, each lane a data word and an operand word, over a valid/ready stream.
- Packs NUM_UNITS lanes into the flattened data_in/operand buses and the mode bit the array consumes.
- Presents the packed frame with a valid/ready handshake and zero-fills lanes missing from a short frame.

---
 rtl/lane_packer_if.sv | 31 +++
 rtl/lane_packer.sv | 98 +++++++++
 tb/tb_lane_packer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lane_packer_if.sv
// rtl/lane_packer_if.sv - lane beat stream in, packed frame out, between a source and lane_packer.
interface lane_packer_if #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(NUM_UNITS) + 1;

  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;
  logic [DATA_WIDTH-1:0]            in_operand;
  logic                             in_mode;
  logic                             in_last;
  logic                             frame_valid;
  logic                             frame_ready;
  logic [NUM_UNITS*DATA_WIDTH-1:0]  data_out;
  logic [NUM_UNITS*DATA_WIDTH-1:0]  operand_out;
  logic                             mode_out;
  logic [CW-1:0]                    lane_count;
  logic                             short_frame;

  modport master (
    output in_valid, in_data, in_operand, in_mode, in_last, frame_ready,
    input  in_ready, frame_valid, data_out, operand_out, mode_out, lane_count, short_frame
  );

  modport slave (
    input  in_valid, in_data, in_operand, in_mode, in_last, frame_ready,
    output in_ready, frame_valid, data_out, operand_out, mode_out, lane_count, short_frame
  );
endinterface

// File: rtl/lane_packer.sv
// rtl/lane_packer.sv - packs NUM_UNITS lane beats into one registered frame for the add/sub array.
module lane_packer #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  lane_packer_if.slave bus
);
  localparam int LW = $clog2(NUM_UNITS);
  localparam int CW = LW + 1;
  localparam int BW = NUM_UNITS * DATA_WIDTH;

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t          r_state, w_state_nxt;
  logic [LW-1:0]   r_lane_idx, w_lane_idx_nxt;
  logic [BW-1:0]   r_data, w_data_nxt;
  logic [BW-1:0]   r_operand, w_operand_nxt;
  logic            r_mode, w_mode_nxt;
  logic            r_short, w_short_nxt;
  logic            r_valid, w_valid_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;

  logic w_in_ready, w_accept, w_handoff, w_last_lane, w_close;

  assign w_in_ready  = (r_state == S_FILL) | ((r_state == S_FULL) & bus.frame_ready);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_handoff   = r_valid & bus.frame_ready;
  assign w_last_lane = (r_lane_idx == LW'(NUM_UNITS - 1));
  assign w_close     = w_accept & (w_last_lane | bus.in_last);

  always_comb begin
    w_state_nxt    = r_state;
    w_lane_idx_nxt = r_lane_idx;
    w_data_nxt     = r_data;
    w_operand_nxt  = r_operand;
    w_mode_nxt     = r_mode;
    w_short_nxt    = r_short;
    w_valid_nxt    = r_valid;
    w_count_nxt    = r_count;

    // Handoff clears first so a beat taken in the same cycle lands in an empty frame.
    if (w_handoff) begin
      w_data_nxt    = '0;
      w_operand_nxt = '0;
      w_mode_nxt    = 1'b0;
      w_short_nxt   = 1'b0;
      w_count_nxt   = '0;
      w_valid_nxt   = 1'b0;
      w_state_nxt   = S_FILL;
    end

    if (w_accept) begin
      w_data_nxt[int'(r_lane_idx)*DATA_WIDTH +: DATA_WIDTH]    = bus.in_data;
      w_operand_nxt[int'(r_lane_idx)*DATA_WIDTH +: DATA_WIDTH] = bus.in_operand;
      w_lane_idx_nxt = r_lane_idx + LW'(1);
      if (w_close) begin
        w_state_nxt    = S_FULL;
        w_valid_nxt    = 1'b1;
        w_mode_nxt     = bus.in_mode;
        w_count_nxt    = CW'(r_lane_idx) + CW'(1);
        w_short_nxt    = ~w_last_lane;
        w_lane_idx_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_lane_idx <= '0;
      r_data     <= '0;
      r_operand  <= '0;
      r_mode     <= 1'b0;
      r_short    <= 1'b0;
      r_valid    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lane_idx <= w_lane_idx_nxt;
      r_data     <= w_data_nxt;
      r_operand  <= w_operand_nxt;
      r_mode     <= w_mode_nxt;
      r_short    <= w_short_nxt;
      r_valid    <= w_valid_nxt;
      r_count    <= w_count_nxt;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.frame_valid = r_valid;
  assign bus.data_out    = r_data;
  assign bus.operand_out = r_operand;
  assign bus.mode_out    = r_mode;
  assign bus.lane_count  = r_count;
  assign bus.short_frame = r_short;
endmodule

// File: tb/tb_lane_packer.sv
// tb/tb_lane_packer.sv - table-driven beats with a frame scoreboard plus hand-written corner sequences.
module tb_lane_packer;
  localparam int NU = 4;
  localparam int DW = 8;

  typedef struct {
    logic [7:0]  d;
    logic [7:0]  op;
    logic        mode;
    logic        last;
    logic        closes;
    logic [31:0] exp_d;
    logic [31:0] exp_op;
    logic        exp_mode;
    logic [2:0]  exp_cnt;
    logic        exp_short;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [31:0] op;
    logic        mode;
    logic [2:0]  cnt;
    logic        sh;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lane_packer_if #(.NUM_UNITS(NU), .DATA_WIDTH(DW)) bus ();

  lane_packer #(.NUM_UNITS(NU), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int     n_pass  = 0;
  int     n_total = 0;
  frame_t sb[$];
  vec_t   tbl[$];
  frame_t mon_f;
  bit     fv_low_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic [7:0] op, input logic mode,
                              input logic last, input logic closes, input logic [31:0] ed,
                              input logic [31:0] eop, input logic em, input logic [2:0] ec,
                              input logic es);
    vec_t v;
    v.d = d; v.op = op; v.mode = mode; v.last = last; v.closes = closes;
    v.exp_d = ed; v.exp_op = eop; v.exp_mode = em; v.exp_cnt = ec; v.exp_short = es;
    return v;
  endfunction

  // Frames are compared on the cycle they are handed off downstream.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.frame_valid) fv_low_seen = 1'b1;
      if (bus.frame_valid && bus.frame_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_frame: got data %0h expected no frame", bus.data_out);
        end else begin
          mon_f = sb.pop_front();
          chk("frame_data",    64'(bus.data_out),    64'(mon_f.d));
          chk("frame_operand", 64'(bus.operand_out), 64'(mon_f.op));
          chk("frame_mode",    64'(bus.mode_out),    64'(mon_f.mode));
          chk("frame_count",   64'(bus.lane_count),  64'(mon_f.cnt));
          chk("frame_short",   64'(bus.short_frame), 64'(mon_f.sh));
        end
      end
    end
  end

  task automatic send_beat(input vec_t v);
    int     n;
    bit     ok;
    frame_t f;
    bus.in_valid   = 1'b1;
    bus.in_data    = v.d;
    bus.in_operand = v.op;
    bus.in_mode    = v.mode;
    bus.in_last    = v.last;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: beat %0h not accepted within 50 cycles, required acceptance", v.d);
    end else if (v.closes) begin
      f.d = v.exp_d; f.op = v.exp_op; f.mode = v.exp_mode; f.cnt = v.exp_cnt; f.sh = v.exp_short;
      sb.push_back(f);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_operand = '0;
    bus.in_mode = 1'b0; bus.in_last = 1'b0; bus.frame_ready = 1'b0;

    tbl.push_back(mk(8'h11, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h22, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h33, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h44, 8'h04, 1, 0, 1, 32'h44332211, 32'h04030201, 1, 3'd4, 0));
    tbl.push_back(mk(8'hAA, 8'h0A, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hBB, 8'h0B, 0, 1, 1, 32'h0000BBAA, 32'h00000B0A, 0, 3'd2, 1));
    tbl.push_back(mk(8'hC1, 8'h1C, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hC2, 8'h2C, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hC3, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hC4, 8'h4C, 0, 1, 1, 32'hC4C3C2C1, 32'h4C3C2C1C, 0, 3'd4, 0));
    tbl.push_back(mk(8'hD1, 8'hE1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hD2, 8'hE2, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hD3, 8'hE3, 0, 1, 1, 32'h00D3D2D1, 32'h00E3E2E1, 0, 3'd3, 1));
    tbl.push_back(mk(8'hF1, 8'h1F, 1, 1, 1, 32'h000000F1, 32'h0000001F, 1, 3'd1, 1));
    tbl.push_back(mk(8'hF2, 8'h2F, 0, 1, 1, 32'h000000F2, 32'h0000002F, 0, 3'd1, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
    chk("rst_data",        64'(bus.data_out),    64'd0);
    chk("rst_operand",     64'(bus.operand_out), 64'd0);
    chk("rst_mode",        64'(bus.mode_out),    64'd0);
    chk("rst_count",       64'(bus.lane_count),  64'd0);
    chk("rst_short",       64'(bus.short_frame), 64'd0);
    chk("rst_in_ready",    64'(bus.in_ready),    64'd1);
    rst_n = 1'b1;

    bus.frame_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_frame_valid", 64'(bus.frame_valid), 64'd0);
      chk("idle_data",        64'(bus.data_out),    64'd0);
      chk("idle_count",       64'(bus.lane_count),  64'd0);
      chk("idle_in_ready",    64'(bus.in_ready),    64'd1);
    end
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) send_beat(tbl[i]);
    drain();

    // Back-pressure: frame held while a new beat waits, then one cycle of frame_ready.
    bus.frame_ready = 1'b0;
    send_beat(mk(8'h61, 8'h16, 0, 0, 0, 0, 0, 0, 0, 0));
    send_beat(mk(8'h62, 8'h26, 0, 0, 0, 0, 0, 0, 0, 0));
    send_beat(mk(8'h63, 8'h36, 0, 0, 0, 0, 0, 0, 0, 0));
    send_beat(mk(8'h64, 8'h46, 0, 0, 1, 32'h64636261, 32'h46362616, 0, 3'd4, 0));
    bus.in_valid = 1'b1; bus.in_data = 8'h99; bus.in_operand = 8'h66;
    bus.in_mode = 1'b0; bus.in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready",    64'(bus.in_ready),    64'd0);
      chk("bp_frame_valid", 64'(bus.frame_valid), 64'd1);
      chk("bp_data",        64'(bus.data_out),    64'h64636261);
      chk("bp_operand",     64'(bus.operand_out), 64'h46362616);
      chk("bp_count",       64'(bus.lane_count),  64'd4);
    end
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_lane0_data",    64'(bus.data_out),    64'h00000099);
    chk("bp_lane0_operand", 64'(bus.operand_out), 64'h00000066);
    chk("bp_lane0_valid",   64'(bus.frame_valid), 64'd0);
    chk("bp_lane0_count",   64'(bus.lane_count),  64'd0);
    @(posedge clk); #1;
    send_beat(mk(8'h77, 8'h55, 1, 1, 1, 32'h00007799, 32'h00005566, 1, 3'd2, 1));
    bus.frame_ready = 1'b1;
    drain();

    // Single-lane frames back to back keep frame_valid high every cycle.
    send_beat(mk(8'hA1, 8'h1A, 0, 1, 1, 32'h000000A1, 32'h0000001A, 0, 3'd1, 1));
    fv_low_seen = 1'b0;
    send_beat(mk(8'hA2, 8'h2A, 1, 1, 1, 32'h000000A2, 32'h0000002A, 1, 3'd1, 1));
    send_beat(mk(8'hA3, 8'h3A, 0, 1, 1, 32'h000000A3, 32'h0000003A, 0, 3'd1, 1));
    send_beat(mk(8'hA4, 8'h4A, 1, 1, 1, 32'h000000A4, 32'h0000004A, 1, 3'd1, 1));
    @(negedge clk);
    chk("single_fv_held", 64'(fv_low_seen), 64'd0);
    @(posedge clk); #1;
    drain();

    // Asynchronous reset in the middle of a partial frame.
    bus.frame_ready = 1'b0;
    send_beat(mk(8'h81, 8'h18, 0, 0, 0, 0, 0, 0, 0, 0));
    send_beat(mk(8'h82, 8'h28, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("pre_rst_data", 64'(bus.data_out), 64'h00008281);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data",     64'(bus.data_out),    64'd0);
    chk("async_rst_operand",  64'(bus.operand_out), 64'd0);
    chk("async_rst_valid",    64'(bus.frame_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready),    64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    send_beat(mk(8'h01, 8'hA1, 0, 0, 0, 0, 0, 0, 0, 0));
    send_beat(mk(8'h02, 8'hA2, 0, 0, 0, 0, 0, 0, 0, 0));
    send_beat(mk(8'h03, 8'hA3, 0, 0, 0, 0, 0, 0, 0, 0));
    send_beat(mk(8'h04, 8'hA4, 0, 0, 1, 32'h04030201, 32'hA4A3A2A1, 0, 3'd4, 0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
